// File: rtl/b_io_l3_in_serialize_b_m_axi_pkg.sv
// Shared types and helpers for the B_IO_L3_in_serialize_B m_axi FIFO slice.
package b_io_l3_in_serialize_b_m_axi_pkg;

    // Width of the shift-register occupancy field; wide enough for any legal DEPTH.
    localparam int CTRL_USED_W = 16;

    // Control state of the FIFO: entries held in the shift register plus
    // the valid bit of the output register.
    typedef struct packed {
        logic [CTRL_USED_W-1:0] used;
        logic                   dout_vld;
    } fifo_ctrl_t;

    // Ceiling log2, returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/b_io_l3_in_serialize_b_m_axi_srl_core.sv
// Shift-only storage for the FIFO. New data enters at mem_q[0]; the oldest
// valid entry sits at index used-1. No reset: contents are tracked by the
// occupancy counter in the parent.
module b_io_l3_in_serialize_b_m_axi_srl_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int ENTRIES    = 62
) (
    input  logic                  clk,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [ENTRIES];

    // Shift every entry one slot deeper and load the new word at the front.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem_q[0] <= din;
            for (int i = 1; i < ENTRIES; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    // Combinational read of the addressed entry; out-of-range indices read zero.
    always_comb begin
        rdata = '0;
        if (32'(raddr) < ENTRIES) begin
            rdata = mem_q[raddr];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/b_io_l3_in_serialize_b_m_axi_srl_fifo_chk.sv
// Protocol and occupancy checks for the shift-register FIFO.
module b_io_l3_in_serialize_b_m_axi_srl_fifo_chk
    import b_io_l3_in_serialize_b_m_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 63
) (
    input logic                   clk,
    input logic                   reset,
    input logic [CTRL_USED_W-1:0] used,
    input logic                   push,
    input logic                   full_n,
    input logic                   empty_n,
    input logic                   rd,
    input logic [DATA_WIDTH-1:0]  dout
);

    a_used_bound: assert property (@(posedge clk) disable iff (reset)
        used <= CTRL_USED_W'(DEPTH - 1));

    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(push && !full_n));

    a_dout_stable: assert property (@(posedge clk) disable iff (reset)
        (empty_n && !rd) |=> $stable(dout));

endmodule

// File: rtl/b_io_l3_in_serialize_b_m_axi_srl_fifo.sv
// Shift-register FIFO with a registered first-word-fall-through output stage,
// occupancy count, almost-full flag and a register-only DEPTH==1 mode.
module b_io_l3_in_serialize_b_m_axi_srl_fifo
    import b_io_l3_in_serialize_b_m_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 63,
    parameter int AF_LEVEL   = DEPTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   num_data_valid
);

    fifo_ctrl_t            ctrl_q;
    fifo_ctrl_t            ctrl_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;
    logic                  push_s;
    logic                  full_n_s;
    logic [ADDR_WIDTH:0]   nd_s;

    generate
        if (DEPTH == 1) begin : g_reg_only
            // Register-only mode: a push loads the output register directly.
            always_comb begin
                full_n_s = ~ctrl_q.dout_vld;
                push_s   = clk_en & if_write & full_n_s;
                ctrl_d   = ctrl_q;
                dout_d   = dout_q;
                ctrl_d.used = '0;
                if (push_s) begin
                    dout_d          = if_din;
                    ctrl_d.dout_vld = 1'b1;
                end else if (clk_en & if_read & ctrl_q.dout_vld) begin
                    ctrl_d.dout_vld = 1'b0;
                end else begin
                    ctrl_d.dout_vld = ctrl_q.dout_vld;
                end
                nd_s = {{ADDR_WIDTH{1'b0}}, ctrl_q.dout_vld};
            end
        end else begin : g_srl
            logic                  pop_s;
            logic [ADDR_WIDTH-1:0] raddr_s;
            logic [DATA_WIDTH-1:0] rdata_s;

            // Next-state for occupancy and output stage. The head is read from
            // the pre-shift array at used-1, so a same-cycle push cannot disturb it.
            always_comb begin
                full_n_s = (ctrl_q.used != CTRL_USED_W'(DEPTH - 1));
                push_s   = clk_en & if_write & full_n_s;
                pop_s    = clk_en & (ctrl_q.used != '0) & (~ctrl_q.dout_vld | if_read);
                raddr_s  = ADDR_WIDTH'(ctrl_q.used - CTRL_USED_W'(1));
                ctrl_d   = ctrl_q;
                dout_d   = dout_q;
                case ({push_s, pop_s})
                    2'b10:   ctrl_d.used = ctrl_q.used + CTRL_USED_W'(1);
                    2'b01:   ctrl_d.used = ctrl_q.used - CTRL_USED_W'(1);
                    default: ctrl_d.used = ctrl_q.used;
                endcase
                if (pop_s) begin
                    dout_d          = rdata_s;
                    ctrl_d.dout_vld = 1'b1;
                end else if (clk_en & if_read & ctrl_q.dout_vld) begin
                    ctrl_d.dout_vld = 1'b0;
                end else begin
                    ctrl_d.dout_vld = ctrl_q.dout_vld;
                end
                nd_s = (ADDR_WIDTH + 1)'(ctrl_q.used) + {{ADDR_WIDTH{1'b0}}, ctrl_q.dout_vld};
            end

            b_io_l3_in_serialize_b_m_axi_srl_core #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .ENTRIES    (DEPTH - 1)
            ) u_core (
                .clk      (clk),
                .shift_en (push_s),
                .din      (if_din),
                .raddr    (raddr_s),
                .rdata    (rdata_s)
            );
        end
    endgenerate

    // State registers; reset wins over clk_en, which is folded into the _d logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= '0;
            dout_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            dout_q <= dout_d;
        end
    end

    assign if_dout        = dout_q;
    assign if_empty_n     = ctrl_q.dout_vld;
    assign if_full_n      = full_n_s;
    assign num_data_valid = nd_s;
    assign if_almost_full = (32'(nd_s) >= $unsigned(AF_LEVEL));

    b_io_l3_in_serialize_b_m_axi_srl_fifo_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_chk (
        .clk     (clk),
        .reset   (reset),
        .used    (ctrl_q.used),
        .push    (push_s),
        .full_n  (full_n_s),
        .empty_n (ctrl_q.dout_vld),
        .rd      (if_read),
        .dout    (dout_q)
    );

endmodule

// File: tb/tb_b_io_l3_in_serialize_b_m_axi_srl_fifo.sv
// Bench for the shift-register FIFO: a DEPTH=4 instance and a DEPTH=1 instance.
module tb_b_io_l3_in_serialize_b_m_axi_srl_fifo;

    typedef struct {
        logic       rst;
        logic       en;
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic       e;
        logic       f;
        logic [2:0] nd;
        logic       af;
        logic [7:0] dout;
    } vec_t;

    logic       clk = 1'b0;
    // DEPTH=4 instance
    logic       rst4 = 1'b1, en4 = 1'b1, wr4 = 1'b0, rd4 = 1'b0;
    logic [7:0] din4 = 8'h00, dout4;
    logic       full_n4, af4, empty_n4;
    logic [2:0] nd4;
    // DEPTH=1 instance
    logic       rst1 = 1'b1, en1 = 1'b1, wr1 = 1'b0, rd1 = 1'b0;
    logic [7:0] din1 = 8'h00, dout1;
    logic       full_n1, af1, empty_n1;
    logic [1:0] nd1;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl4[$];
    vec_t tbl1[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    b_io_l3_in_serialize_b_m_axi_srl_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .AF_LEVEL(3)
    ) dut4 (
        .clk(clk), .reset(rst4), .clk_en(en4), .if_write(wr4), .if_din(din4),
        .if_full_n(full_n4), .if_almost_full(af4), .if_read(rd4), .if_dout(dout4),
        .if_empty_n(empty_n4), .num_data_valid(nd4)
    );

    b_io_l3_in_serialize_b_m_axi_srl_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(1), .AF_LEVEL(1)
    ) dut1 (
        .clk(clk), .reset(rst1), .clk_en(en1), .if_write(wr1), .if_din(din1),
        .if_full_n(full_n1), .if_almost_full(af1), .if_read(rd1), .if_dout(dout1),
        .if_empty_n(empty_n1), .num_data_valid(nd1)
    );

    function automatic vec_t mk(logic rst, logic en, logic wr, logic [7:0] din, logic rd,
                                logic e, logic f, logic [2:0] nd, logic af, logic [7:0] dout);
        vec_t v;
        v.rst = rst; v.en = en; v.wr = wr; v.din = din; v.rd = rd;
        v.e = e; v.f = f; v.nd = nd; v.af = af; v.dout = dout;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic wr, input logic [7:0] din, input logic rd);
        rst4 = 1'b0; en4 = 1'b1; wr4 = wr; din4 = din; rd4 = rd;
    endtask

    initial begin
        // rst en wr din rd | empty_n full_n nd af dout  (outputs after the edge)
        tbl4.push_back(mk(1,1,0,8'h00,0, 0,1,3'd0,0,8'h00));
        tbl4.push_back(mk(0,1,1,8'hA1,0, 0,1,3'd1,0,8'h00));
        tbl4.push_back(mk(0,1,0,8'h00,0, 1,1,3'd1,0,8'hA1));
        tbl4.push_back(mk(0,1,0,8'h00,1, 0,1,3'd0,0,8'hA1));
        tbl4.push_back(mk(0,1,1,8'h01,0, 0,1,3'd1,0,8'hA1));
        tbl4.push_back(mk(0,1,1,8'h02,0, 1,1,3'd2,0,8'h01));
        tbl4.push_back(mk(0,1,1,8'h03,0, 1,1,3'd3,1,8'h01));
        tbl4.push_back(mk(0,1,1,8'h04,0, 1,0,3'd4,1,8'h01));
        tbl4.push_back(mk(0,1,1,8'h05,0, 1,0,3'd4,1,8'h01));
        tbl4.push_back(mk(0,1,0,8'h00,1, 1,1,3'd3,1,8'h02));
        tbl4.push_back(mk(0,1,0,8'h00,1, 1,1,3'd2,0,8'h03));
        tbl4.push_back(mk(0,1,0,8'h00,1, 1,1,3'd1,0,8'h04));
        tbl4.push_back(mk(0,1,0,8'h00,1, 0,1,3'd0,0,8'h04));
        tbl4.push_back(mk(0,1,1,8'h10,0, 0,1,3'd1,0,8'h04));
        tbl4.push_back(mk(0,1,1,8'h11,0, 1,1,3'd2,0,8'h10));
        tbl4.push_back(mk(0,0,1,8'h12,1, 1,1,3'd2,0,8'h10));
        tbl4.push_back(mk(0,0,1,8'h12,1, 1,1,3'd2,0,8'h10));
        tbl4.push_back(mk(0,0,1,8'h12,1, 1,1,3'd2,0,8'h10));
        tbl4.push_back(mk(0,1,1,8'h12,1, 1,1,3'd2,0,8'h11));
        tbl4.push_back(mk(0,1,0,8'h00,1, 1,1,3'd1,0,8'h12));
        tbl4.push_back(mk(0,1,0,8'h00,1, 0,1,3'd0,0,8'h12));
        tbl4.push_back(mk(0,1,1,8'h20,0, 0,1,3'd1,0,8'h12));
        tbl4.push_back(mk(0,1,1,8'h21,0, 1,1,3'd2,0,8'h20));
        tbl4.push_back(mk(0,1,1,8'h22,0, 1,1,3'd3,1,8'h20));
        tbl4.push_back(mk(1,1,1,8'h99,0, 0,1,3'd0,0,8'h00));
        tbl4.push_back(mk(0,1,1,8'h7E,0, 0,1,3'd1,0,8'h00));
        tbl4.push_back(mk(0,1,0,8'h00,0, 1,1,3'd1,0,8'h7E));
        tbl4.push_back(mk(0,1,0,8'h00,1, 0,1,3'd0,0,8'h7E));

        tbl1.push_back(mk(1,1,0,8'h00,0, 0,1,3'd0,0,8'h00));
        tbl1.push_back(mk(0,1,1,8'h33,0, 1,0,3'd1,1,8'h33));
        tbl1.push_back(mk(0,1,1,8'h44,1, 0,1,3'd0,0,8'h33));
        tbl1.push_back(mk(0,1,1,8'h44,0, 1,0,3'd1,1,8'h44));
        tbl1.push_back(mk(0,1,0,8'h00,1, 0,1,3'd0,0,8'h44));
        tbl1.push_back(mk(0,0,1,8'h55,0, 0,1,3'd0,0,8'h44));

        tick();

        // Table-driven vectors on the DEPTH=4 instance
        for (int i = 0; i < tbl4.size(); i++) begin
            rst4 = tbl4[i].rst; en4 = tbl4[i].en; wr4 = tbl4[i].wr;
            din4 = tbl4[i].din; rd4 = tbl4[i].rd;
            tick();
            chk("d4_empty_n", i, 32'(empty_n4), 32'(tbl4[i].e));
            chk("d4_full_n",  i, 32'(full_n4),  32'(tbl4[i].f));
            chk("d4_count",   i, 32'(nd4),      32'(tbl4[i].nd));
            chk("d4_afull",   i, 32'(af4),      32'(tbl4[i].af));
            chk("d4_dout",    i, 32'(dout4),    32'(tbl4[i].dout));
        end

        // Prime two entries, then sustained write+read with a scoreboard
        drive4(1'b1, 8'h30, 1'b0); exp_q.push_back(8'h30); tick();
        drive4(1'b1, 8'h31, 1'b0); exp_q.push_back(8'h31); tick();
        chk("prime_count", 0, 32'(nd4), 32'd2);
        for (int k = 0; k < 20; k++) begin
            drive4(1'b1, 8'h40 + 8'(k), 1'b1);
            chk("stream_vld", k, 32'(empty_n4), 32'd1);
            if (exp_q.size() != 0) begin
                chk("stream_dout", k, 32'(dout4), 32'(exp_q.pop_front()));
            end else begin
                chk("stream_sb_empty", k, 32'd1, 32'd0);
            end
            exp_q.push_back(8'h40 + 8'(k));
            tick();
            chk("stream_count", k, 32'(nd4), 32'd2);
        end
        // Drain what is left, bounded
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
            drive4(1'b0, 8'h00, 1'b1);
            if (empty_n4) begin
                chk("drain_dout", k, 32'(dout4), 32'(exp_q.pop_front()));
            end else begin
                chk("drain_dout", k, 32'(dout4), 32'(dout4));
            end
            tick();
        end
        chk("drain_left", 0, 32'(exp_q.size()), 32'd0);
        drive4(1'b0, 8'h00, 1'b0);
        tick();
        chk("drain_empty_n", 0, 32'(empty_n4), 32'd0);
        chk("drain_count", 0, 32'(nd4), 32'd0);

        // Register-only DEPTH=1 instance
        for (int i = 0; i < tbl1.size(); i++) begin
            rst1 = tbl1[i].rst; en1 = tbl1[i].en; wr1 = tbl1[i].wr;
            din1 = tbl1[i].din; rd1 = tbl1[i].rd;
            tick();
            chk("d1_empty_n", i, 32'(empty_n1), 32'(tbl1[i].e));
            chk("d1_full_n",  i, 32'(full_n1),  32'(tbl1[i].f));
            chk("d1_count",   i, 32'(nd1),      32'(tbl1[i].nd));
            chk("d1_afull",   i, 32'(af1),      32'(tbl1[i].af));
            chk("d1_dout",    i, 32'(dout1),    32'(tbl1[i].dout));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
